// File: rtl/spi_pkg.sv
// Shared definitions for the bit-reversing SPI slave.
// Holds the FSM state encoding and the width of the frame counter.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_RX   = 2'd0,
    ST_TX   = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchroniser for the asynchronous SPI pins plus sck edge detection.
// Ports:
//   clock, reset      system clock, async active-high reset
//   sck, ss, mosi     raw SPI pins
//   ss_s, mosi_s      synchronised slave select and data
//   lead, trail       1-cycle pulses when the synchronised sck leaves / returns to CPOL
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit CPOL        = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic sck,
  input  logic ss,
  input  logic mosi,
  output logic ss_s,
  output logic mosi_s,
  output logic lead,
  output logic trail
);

  logic [SYNC_STAGES-1:0] sck_pipe;
  logic [SYNC_STAGES-1:0] ss_pipe;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic                   sck_d;
  logic                   sck_s;

  // sck resets to its idle level and ss to deselected so that leaving
  // reset never looks like an edge or the start of a frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_pipe  <= {SYNC_STAGES{CPOL}};
      ss_pipe   <= '1;
      mosi_pipe <= '0;
      sck_d     <= CPOL;
    end else begin
      sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], sck};
      ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], ss};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_pipe[SYNC_STAGES-1];
    end
  end

  assign sck_s  = sck_pipe[SYNC_STAGES-1];
  assign ss_s   = ss_pipe[SYNC_STAGES-1];
  assign mosi_s = mosi_pipe[SYNC_STAGES-1];

  assign lead  = (sck_d == CPOL) && (sck_s != CPOL);
  assign trail = (sck_d != CPOL) && (sck_s == CPOL);

endmodule

// File: rtl/spi_bitrev_slave.sv
// Oversampled SPI slave that receives a word and returns it bit-reversed.
// Ports:
//   clock, reset   system clock, async active-high reset
//   sck, ss, mosi  SPI pins (asynchronous to clock)
//   miso           serial data out, 1 when not transmitting
//   busy           synchronised ss is low
//   rx_word        last complete received word
//   word_valid     pulse per completed RX word
//   frame_done     pulse on ss rise after at least one full TX word
//   abort          pulse on ss rise in the middle of a word
//   frame_cnt      number of frame_done events (wraps)
//
// state   | meaning
// ST_RX   | shifting a word in on sample edges
// ST_TX   | returning the reversed word on shift edges
// ST_DONE | word returned, ignoring sck until ss rises
module spi_bitrev_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2,
  parameter bit BURST       = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sck,
  input  logic                   ss,
  input  logic                   mosi,
  output logic                   miso,
  output logic                   busy,
  output logic [DATA_W-1:0]      rx_word,
  output logic                   word_valid,
  output logic                   frame_done,
  output logic                   abort,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            state;
  state_t            state_nxt;
  logic              ss_s;
  logic              mosi_s;
  logic              lead;
  logic              trail;
  logic              ss_prev;
  logic              ss_rise;
  logic              sample_edge;
  logic              shift_edge;
  logic [CNT_W-1:0]  cnt;
  // The oldest received bit falls out on the final sample, so only
  // DATA_W-1 bits ever need to be held between samples.
  logic [DATA_W-2:0] rx_sh;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_sh;
  logic              tx_done_seen;
  logic              rx_last;
  logic              tx_last;
  logic              rx_take;
  logic              tx_shift;
  logic              tx_finish;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .CPOL       (CPOL)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .sck   (sck),
    .ss    (ss),
    .mosi  (mosi),
    .ss_s  (ss_s),
    .mosi_s(mosi_s),
    .lead  (lead),
    .trail (trail)
  );

  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;
  assign ss_rise     = ss_s & ~ss_prev;
  assign rx_last     = (cnt == CNT_W'(DATA_W - 1));
  assign tx_last     = (cnt == CNT_W'(DATA_W));
  assign rx_next     = {rx_sh, mosi_s};
  assign busy        = ~ss_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_RX;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ss_s) begin
      state_nxt = ST_RX;
    end else begin
      case (state)
        ST_RX:   if (sample_edge && rx_last) state_nxt = ST_TX;
        ST_TX:   if (sample_edge && tx_last) state_nxt = BURST ? ST_RX : ST_DONE;
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_RX;
      endcase
    end
  end

  // TX ends on the sample edge after the last bit was driven, so the
  // master has captured that bit before miso returns high.
  always_comb begin
    rx_take   = 1'b0;
    tx_shift  = 1'b0;
    tx_finish = 1'b0;
    if (!ss_s) begin
      case (state)
        ST_RX: rx_take = sample_edge;
        ST_TX: begin
          tx_shift  = shift_edge && !tx_last;
          tx_finish = sample_edge && tx_last;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      rx_sh        <= '0;
      tx_sh        <= '0;
      rx_word      <= '0;
      word_valid   <= 1'b0;
      frame_done   <= 1'b0;
      abort        <= 1'b0;
      frame_cnt    <= '0;
      miso         <= 1'b1;
      ss_prev      <= 1'b1;
      tx_done_seen <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      abort      <= 1'b0;
      ss_prev    <= ss_s;
      if (ss_s) begin
        // Deselect overrides any sck edge seen in the same cycle.
        cnt          <= '0;
        miso         <= 1'b1;
        tx_done_seen <= 1'b0;
        if (ss_rise) begin
          if (cnt != '0) begin
            abort <= 1'b1;
          end else if (tx_done_seen) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 1'b1;
          end
        end
      end else begin
        if (rx_take) begin
          rx_sh <= rx_next[DATA_W-2:0];
          if (rx_last) begin
            rx_word    <= rx_next;
            tx_sh      <= rx_next;
            word_valid <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        if (tx_shift) begin
          miso  <= tx_sh[0];
          tx_sh <= tx_sh >> 1;
          cnt   <= cnt + 1'b1;
        end
        if (tx_finish) begin
          miso         <= 1'b1;
          cnt          <= '0;
          tx_done_seen <= 1'b1;
        end
      end
    end
  end

endmodule
